// File: rtl/nms_stream.sv
// nms_stream: streaming non-maximum suppression.
//
// Takes a raster-order stream of gradient magnitude and quantized direction
// (0:0deg, 1:45deg, 2:90deg, 3:135deg). It keeps each pixel's magnitude only
// when that pixel is a local maximum along its gradient direction, and
// outputs 0 otherwise. Border pixels always produce 0.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_mag, in_angle     gradient magnitude (unsigned) and direction code
//   out_valid/out_ready  output handshake
//   out_mag              suppressed magnitude
//   out_eof              high with the last pixel of the frame
//
// Latency: output k is loaded on the same clock edge that accepts input
// k+IMG_W+1. At that edge the full 3x3 neighbourhood of pixel k is available.
module nms_stream #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int MAG_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_mag,
    input  logic [1:0]       in_angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W-1:0] out_mag,
    output logic             out_eof
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int PIX_W = MAG_W + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [COL_W-1:0]   in_col_q, in_col_d;
    logic [COL_W-1:0]   out_c_q, out_c_d, next_c;
    logic [ROW_W-1:0]   out_r_q, out_r_d, next_r;
    logic               out_valid_q, out_valid_d;
    logic               out_eof_q, out_eof_d;
    logic [MAG_W-1:0]   out_mag_q, out_mag_d;

    // Window entries are {angle, mag}. Row 0 is the line above the centre,
    // and column 2 holds the newest pixel.
    logic [PIX_W-1:0]   win_q  [3][3];
    logic [PIX_W-1:0]   win_d  [3][3];
    logic [PIX_W-1:0]   win_sh [3][3];

    logic [PIX_W-1:0]   lb1_mem [IMG_W];
    logic [PIX_W-1:0]   lb2_mem [IMG_W];
    logic [PIX_W-1:0]   lb1_rd, lb2_rd, in_pix;

    logic               accept, border, last_pos;
    logic [MAG_W-1:0]   centre, nb_a, nb_b, keep_mag;
    logic [1:0]         dir;

    assign in_pix = {in_angle, in_mag};
    assign lb1_rd = lb1_mem[in_col_q];
    assign lb2_rd = lb2_mem[in_col_q];

    // in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            FILL:    in_ready = 1'b1;
            STREAM:  in_ready = !out_valid_q || out_ready;
            default: in_ready = 1'b0;
        endcase
        in_ready = in_ready && rst_n;
    end

    assign accept = in_valid && in_ready;

    // Window contents as they will look after the incoming pixel is shifted
    // in. The output is computed from this so that it can be registered on
    // the accepting edge.
    always_comb begin
        for (int rr = 0; rr < 3; rr++) begin
            win_sh[rr][0] = win_q[rr][1];
            win_sh[rr][1] = win_q[rr][2];
        end
        win_sh[0][2] = lb2_rd;
        win_sh[1][2] = lb1_rd;
        win_sh[2][2] = in_pix;
    end

    // Choose the two neighbours along the gradient direction of the centre
    // pixel and apply the border and local-maximum keep rules.
    always_comb begin
        centre = win_sh[1][1][MAG_W-1:0];
        dir    = win_sh[1][1][PIX_W-1:MAG_W];
        case (dir)
            2'd0: begin
                nb_a = win_sh[1][0][MAG_W-1:0];
                nb_b = win_sh[1][2][MAG_W-1:0];
            end
            2'd1: begin
                nb_a = win_sh[0][2][MAG_W-1:0];
                nb_b = win_sh[2][0][MAG_W-1:0];
            end
            2'd2: begin
                nb_a = win_sh[0][1][MAG_W-1:0];
                nb_b = win_sh[2][1][MAG_W-1:0];
            end
            default: begin
                nb_a = win_sh[0][0][MAG_W-1:0];
                nb_b = win_sh[2][2][MAG_W-1:0];
            end
        endcase
        // The border test also removes windows that wrap across line ends.
        border = (out_r_q == '0) || (out_r_q == ROW_LAST) ||
                 (out_c_q == '0) || (out_c_q == COL_LAST);
        keep_mag = (!border && centre >= nb_a && centre >= nb_b) ? centre : '0;
    end

    // Raster position of the next output pixel after the current one.
    always_comb begin
        next_c = out_c_q + COL_W'(1);
        next_r = out_r_q;
        if (out_c_q == COL_LAST) begin
            next_c = '0;
            next_r = (out_r_q == ROW_LAST) ? '0 : out_r_q + ROW_W'(1);
        end
        last_pos = (out_r_q == ROW_LAST) && (out_c_q == COL_LAST);
    end

    // Next-state logic for the control FSM, counters and the output slot.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        in_col_d    = in_col_q;
        out_c_d     = out_c_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q && !out_ready;
        out_mag_d   = out_mag_q;
        out_eof_d   = out_eof_q;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                win_d[rr][cc] = win_q[rr][cc];

        if (accept) begin
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    win_d[rr][cc] = win_sh[rr][cc];
            in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + COL_W'(1);
            in_cnt_d = (in_cnt_q == CNT_LAST) ? '0 : in_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            FILL: begin
                if (accept && in_cnt_q == CNT_W'(IMG_W))
                    state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_mag_d   = keep_mag;
                    out_eof_d   = 1'b0;
                    out_c_d     = next_c;
                    out_r_d     = next_r;
                    if (in_cnt_q == CNT_LAST)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                // The remaining pixels are all on the border, so they are
                // zero. After the eof pixel is loaded, wait for it to leave.
                if (out_eof_q) begin
                    if (out_valid_q && out_ready) begin
                        state_d   = FILL;
                        out_eof_d = 1'b0;
                        out_c_d   = '0;
                        out_r_d   = '0;
                    end
                end else if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_mag_d   = '0;
                    out_eof_d   = last_pos;
                    out_c_d     = next_c;
                    out_r_d     = next_r;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            in_cnt_q    <= '0;
            in_col_q    <= '0;
            out_c_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_eof_q   <= 1'b0;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    win_q[rr][cc] <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            in_col_q    <= in_col_d;
            out_c_q     <= out_c_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            out_mag_q   <= out_mag_d;
            out_eof_q   <= out_eof_d;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    win_q[rr][cc] <= win_d[rr][cc];
        end
    end

    // Line buffers: lb1 delays the stream by one line and lb2 by two lines.
    // Their contents are not reset; stale entries only reach border outputs,
    // which are forced to zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[in_col_q] <= in_pix;
            lb2_mem[in_col_q] <= lb1_rd;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_nms_stream.sv
// tb_nms_stream: self-checking bench for nms_stream using an 8x6 image.
// Expected outputs are computed from a row/column reference model of the
// suppression rules and compared on every output transfer.
module tb_nms_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int MW = 11;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_mag;
    logic [1:0]    in_angle;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_mag;
    logic          out_eof;

    int checks = 0;
    int errors = 0;

    logic [MW-1:0] fMag [N];
    logic [1:0]    fAng [N];

    nms_stream #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    // Reference model: magnitude at image coordinate (r,c).
    function automatic int pixAt(int r, int c);
        return int'(fMag[r * W + c]);
    endfunction

    // Reference model: expected suppressed output for pixel index k.
    function automatic int expMag(int k);
        int r = k / W;
        int c = k % W;
        int cen = int'(fMag[k]);
        int a;
        int b;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        case (fAng[k])
            2'd0: begin a = pixAt(r, c - 1);     b = pixAt(r, c + 1);     end
            2'd1: begin a = pixAt(r - 1, c + 1); b = pixAt(r + 1, c - 1); end
            2'd2: begin a = pixAt(r - 1, c);     b = pixAt(r + 1, c);     end
            default: begin a = pixAt(r - 1, c - 1); b = pixAt(r + 1, c + 1); end
        endcase
        return (cen >= a && cen >= b) ? cen : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present the pixel at index ip. If the previous offer is still pending,
    // keep it unchanged.
    task automatic applyStimulus(input int ip, input bit randMode, input bit hold);
        if (!hold) begin
            in_valid = (ip < N) && (!randMode || $urandom_range(0, 3) != 0);
            if (ip < N) begin
                in_mag   = fMag[ip];
                in_angle = fAng[ip];
            end
        end
        out_ready = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Stream one frame. Stop after stopAfter inputs are accepted, or once all
    // N outputs have been seen.
    task automatic runFrame(input int stopAfter, input bit randMode);
        int ip = 0;
        int nOut = 0;
        int cyc = 0;
        bit inX = 1'b0;
        bit sawFirst = 1'b0;
        bit prevHold = 1'b0;
        logic [MW-1:0] prevMag = '0;
        while (nOut < N && ip < stopAfter) begin
            @(negedge clk);
            applyStimulus(ip, randMode, in_valid && !inX && ip < N);
            #1;
            if (prevHold) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_mag", 32'(out_mag), 32'(prevMag));
            end
            if (ip <= W)
                checkOutput("fill_ready", 32'(in_ready), 32'd1);
            else if (ip < N)
                checkOutput("stream_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            else
                checkOutput("flush_ready", 32'(in_ready), 32'd0);
            if (out_valid && !sawFirst) begin
                sawFirst = 1'b1;
                checkOutput("first_latency", 32'(ip), 32'(W + 2));
            end
            inX = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checkOutput("out_mag", 32'(out_mag), 32'(expMag(nOut)));
                checkOutput("out_eof", 32'(out_eof), 32'(nOut == N - 1));
                nOut++;
            end
            prevHold = out_valid && !out_ready;
            prevMag  = out_mag;
            @(posedge clk);
            if (inX) ip++;
            cyc++;
            if (cyc > 1500) begin
                checkOutput("frame_timeout", 32'(nOut), 32'(N));
                break;
            end
        end
        if (nOut == N) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            checkOutput("post_ready", 32'(in_ready), 32'd1);
            checkOutput("post_valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < N; i++) begin
            fMag[i] = MW'($urandom_range(0, 31));
            fAng[i] = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mag    = '0;
        in_angle  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_mag", 32'(out_mag), 32'd0);
        checkOutput("reset_out_eof", 32'(out_eof), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] uniform frame, angle 0");
        for (int i = 0; i < N; i++) begin fMag[i] = 11'd10; fAng[i] = 2'd0; end
        runFrame(N + 1, 1'b0);

        $display("[TB] angle 2, bright row 3");
        for (int i = 0; i < N; i++) begin
            fMag[i] = (i / W == 3) ? 11'd50 : 11'd20;
            fAng[i] = 2'd2;
        end
        runFrame(N + 1, 1'b0);

        $display("[TB] angle 1, (2,2)=40 (1,3)=45");
        for (int i = 0; i < N; i++) begin fMag[i] = 11'd5; fAng[i] = 2'd1; end
        fMag[2 * W + 2] = 11'd40;
        fMag[1 * W + 3] = 11'd45;
        runFrame(N + 1, 1'b0);

        $display("[TB] angle 1, values swapped");
        fMag[2 * W + 2] = 11'd45;
        fMag[1 * W + 3] = 11'd40;
        runFrame(N + 1, 1'b0);

        $display("[TB] random frame, random handshakes");
        fillRandom();
        runFrame(N + 1, 1'b1);

        $display("[TB] reset mid-frame");
        fillRandom();
        runFrame(20, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_out_mag", 32'(out_mag), 32'd0);
        checkOutput("midreset_out_eof", 32'(out_eof), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fillRandom();
        runFrame(N + 1, 1'b1);

        $display("[TB] back-to-back frames");
        fillRandom();
        runFrame(N + 1, 1'b0);
        fillRandom();
        runFrame(N + 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
